// File: rtl/clk_div_pkg.sv
// Shared constants and ratio helpers for the clock-divider bank.
// Latency: n/a (pure functions, no state).
// Backpressure: n/a.
package clk_div_pkg;

  // Smallest ratio that still produces a proper high/low square wave.
  localparam int unsigned DIV_MIN = 2;

  // Requested ratios below DIV_MIN are raised to DIV_MIN.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  // High-phase length of a period; odd ratios round down (short-high).
  function automatic int unsigned half_div(input int unsigned r);
    return r >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadowed active ratio, registered div/strobe/pending.
// Latency: div_o/stb_o are registered from cnt_q, one cycle behind the counter.
// Backpressure: none; en_i low freezes all state, sync_i overrides enable.
//
// Ports:
//   clk_i   system clock (posedge)      rst_ni  async active-low reset
//   en_i    count enable                sync_i  phase realign / ratio load
//   div_i   requested ratio (raw)       div_o   square wave
//   stb_o   1-cycle terminal strobe     pend_o  requested != active ratio
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             div_o,
  output logic             stb_o,
  output logic             pend_o
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ract_q, ract_d;
  logic             div_q, div_d;
  logic             stb_q, stb_d;
  logic             pend_q, pend_d;

  logic [DIV_W-1:0] rreq;
  logic [DIV_W-1:0] half;
  logic             term;

  assign rreq = DIV_W'(clamp_div(32'(div_i)));
  assign half = DIV_W'(half_div(32'(ract_q)));
  assign term = (cnt_q == (ract_q - ONE));

  always_comb begin
    cnt_d  = cnt_q;
    ract_d = ract_q;
    div_d  = div_q;
    stb_d  = 1'b0;
    if (sync_i) begin
      // Realign wins over everything, including a coincident terminal count.
      cnt_d  = '0;
      ract_d = rreq;
      div_d  = 1'b0;
    end else if (!en_i) begin
      // Hold; stb_d already 0 so a strobe is never stretched while frozen.
    end else if (term) begin
      // The only point where a new ratio is adopted outside of sync, so a
      // period in flight always completes at its original length.
      cnt_d  = '0;
      ract_d = rreq;
      stb_d  = 1'b1;
      div_d  = 1'b0;
    end else begin
      cnt_d  = cnt_q + ONE;
      div_d  = (cnt_q < half);
    end
    pend_d = (rreq != ract_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      ract_q <= DEF_VAL;
      div_q  <= 1'b0;
      stb_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ract_q <= ract_d;
      div_q  <= div_d;
      stb_q  <= stb_d;
      pend_q <= pend_d;
    end
  end

  assign div_o  = div_q;
  assign stb_o  = stb_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of phase-locked programmable clock dividers sharing enable and sync.
// Latency: outputs registered, one cycle behind each channel's counter.
// Backpressure: none; iEn low freezes every channel, iSync realigns all of them.
//
// Ports:
//   iClkIN  system clock                 reset  async active-low reset
//   iEn     common count enable          iSync  common phase realign
//   iDiv    packed ratios, channel k = iDiv[k*DIV_W +: DIV_W]
//   oDiv    square wave per channel      oStb   terminal strobe per channel
//   oPend   ratio change pending per channel
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int DEF_DIV  = 2
) (
  input  logic                      iClkIN,
  input  logic                      reset,
  input  logic                      iEn,
  input  logic                      iSync,
  input  logic [CHANNELS*DIV_W-1:0] iDiv,
  output logic [CHANNELS-1:0]       oDiv,
  output logic [CHANNELS-1:0]       oStb,
  output logic [CHANNELS-1:0]       oPend
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    clk_div_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_i (iClkIN),
      .rst_ni(reset),
      .en_i  (iEn),
      .sync_i(iSync),
      .div_i (iDiv[k*DIV_W +: DIV_W]),
      .div_o (oDiv[k]),
      .stb_o (oStb[k]),
      .pend_o(oPend[k])
    );
  end

endmodule
